hilo_div_unit: RTL and testbench

Downstream consumer of the ALU's multiply outputs. Owns the architectural HI/LO registers.
- Latches the ALU's combinational MULT/MULTU product.
- Services MTHI/MTLO writes.
- Runs DIV/DIVU as an iterative 32-step restoring divider. The ALU has no divider.
- Drives `busy` so the CPU stalls MFHI/MFLO and further HI/LO operations until the divide completes.

---
 rtl/hilo_div_unit_pkg.sv | 26 ++
 rtl/hilo_div_unit_div_step.sv | 28 ++
 rtl/hilo_div_unit.sv | 134 +++++++++++++
 tb/tb_hilo_div_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_unit_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO register and divide unit.
// Holds the divider state encoding, step count, divide-by-zero quotient value,
// and a small helper for taking operand magnitudes.
package hilo_pkg;

    localparam int WIDTH     = 32;
    localparam int CNT_W     = 6;
    localparam int DIV_STEPS = 32;

    // Quotient written to LO when the divisor is zero, signed or unsigned
    localparam logic [WIDTH-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    // Magnitude of a two's complement operand; passes the value through when
    // the operation is unsigned or the value is already non-negative
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] value,
                                                input logic             isSigned);
        return (isSigned && value[WIDTH-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// div_step: one combinational iteration of a restoring divider.
// The dividend is held in the quotient register and shifts into the partial
// remainder one bit per step while quotient bits shift in from the right.
module div_step
    import hilo_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;

    // Shift {rem, quo} left and subtract the divisor when it fits; the
    // difference always fits in WIDTH bits because rem stays below divisor
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        rem_o   = shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, divisor_i}) begin
            rem_o = shifted[WIDTH-1:0] - divisor_i;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: architectural HI/LO registers plus an iterative 32-step
// restoring divider. Captures multiply products and MTHI/MTLO writes, and
// holds busy high while a DIV/DIVU runs so the CPU can stall HI/LO users.
// Optional build macro DIV_ZERO_FAST_EN: a divide by zero skips the
// iteration phase and completes one edge after it starts.
module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_en,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic             div_start,
    input  logic             unsign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_done
);

    import hilo_pkg::*;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] origDividend_q;
    logic             quoNeg_q;
    logic             remNeg_q;
    logic             divZero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (div_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Control FSM and HI/LO ownership: accepts one operation in IDLE, iterates
    // in RUN, applies sign fix-up and writes the result in FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            div_q          <= '0;
            origDividend_q <= '0;
            quoNeg_q       <= 1'b0;
            remNeg_q       <= 1'b0;
            divZero_q      <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        quo_q          <= absVal(dividend, !unsign);
                        div_q          <= absVal(divisor, !unsign);
                        rem_q          <= '0;
                        cnt_q          <= '0;
                        origDividend_q <= dividend;
                        quoNeg_q       <= !unsign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        remNeg_q       <= !unsign && dividend[WIDTH-1];
                        divZero_q      <= (divisor == '0);
                        busy_q         <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        state_q        <= (divisor == '0) ? FIX : RUN;
`else
                        state_q        <= RUN;
`endif
                    end else if (mult_en) begin
                        hi_q <= alu_hi;
                        lo_q <= alu_lo;
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (divZero_q) begin
                        hi_q <= origDividend_q;
                        lo_q <= DIV_ZERO_QUO;
                    end else begin
                        hi_q <= remNeg_q ? (~rem_q + 1'b1) : rem_q;
                        lo_q <= quoNeg_q ? (~quo_q + 1'b1) : quo_q;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign div_done = done_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: scoreboard bench for the HI/LO divide unit. Expected HI/LO
// pairs are queued when an operation is driven and popped when the unit
// reports its result. Honors DIV_ZERO_FAST_EN for divide-by-zero latency.
module tb_hilo_div_unit;

    logic        clk;
    logic        reset;
    logic        mult_en;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        div_start;
    logic        unsign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        div_done;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        expQ[$];
    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] modelHi     = 32'h0;
    logic [31:0] modelLo     = 32'h0;

    hilo_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mult_en   (mult_en),
        .alu_hi    (alu_hi),
        .alu_lo    (alu_lo),
        .div_start (div_start),
        .unsign    (unsign),
        .dividend  (dividend),
        .divisor   (divisor),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .div_done  (div_done)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Compare the oldest queued expectation against current HI/LO
    task automatic popAndCheck(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({e.tag, "_hi"}, hi, e.hi);
            checkOutput({e.tag, "_lo"}, lo, e.lo);
            modelHi = e.hi;
            modelLo = e.lo;
        end
    endtask

    // Single-edge operations in IDLE: multiply capture and MTHI/MTLO
    task automatic applyStimulus(input string tag, input logic doMult, input logic doHi,
                                 input logic doLo, input logic [31:0] aHi,
                                 input logic [31:0] aLo, input logic [31:0] wd,
                                 input logic [31:0] expHi, input logic [31:0] expLo);
        exp_t e;
        e.tag = tag; e.hi = expHi; e.lo = expLo;
        expQ.push_back(e);
        @(negedge clk);
        mult_en = doMult; mthi = doHi; mtlo = doLo;
        alu_hi = aHi; alu_lo = aLo; wdata = wd;
        @(posedge clk); #1;
        mult_en = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        popAndCheck(tag);
    endtask

    // Full divide: checks E0 hold, busy length, single done pulse, and result;
    // optionally fires mult/move/start requests mid-run that must be ignored
    task automatic applyDivide(input string tag, input logic u, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input logic withMult,
                               input logic disturb);
        exp_t e;
        int   cycles;
        int   dones;
        int   expCycles;
        expCycles = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'h0) expCycles = 1;
`endif
        e.tag = tag; e.hi = expHi; e.lo = expLo;
        expQ.push_back(e);
        @(negedge clk);
        unsign = u; dividend = a; divisor = b; div_start = 1'b1;
        mult_en = withMult; alu_hi = 32'h0000_0055; alu_lo = 32'h0000_0066;
        @(posedge clk); #1;
        div_start = 1'b0; mult_en = 1'b0;
        checkOutput({tag, "_e0_busy"}, {31'h0, busy}, 32'h1);
        checkOutput({tag, "_e0_hiHold"}, hi, modelHi);
        checkOutput({tag, "_e0_loHold"}, lo, modelLo);
        cycles = 0;
        dones  = 0;
        while (busy && cycles < 100) begin
            if (disturb && cycles == 5) begin
                mthi = 1'b1; mtlo = 1'b1; mult_en = 1'b1; div_start = 1'b1;
                wdata = 32'hDEAD_BEEF; alu_hi = 32'h1111_1111; alu_lo = 32'h2222_2222;
            end
            if (disturb && cycles == 7) begin
                mthi = 1'b0; mtlo = 1'b0; mult_en = 1'b0; div_start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (div_done) dones++;
            if (disturb && cycles == 8) begin
                checkOutput({tag, "_lockHi"}, hi, modelHi);
                checkOutput({tag, "_lockLo"}, lo, modelLo);
            end
        end
        checkOutput({tag, "_busyCycles"}, 32'(cycles), 32'(expCycles));
        checkOutput({tag, "_donePulses"}, 32'(dones), 32'd1);
        checkOutput({tag, "_doneNow"}, {31'h0, div_done}, 32'h1);
        popAndCheck(tag);
        @(posedge clk); #1;
        checkOutput({tag, "_doneDrop"}, {31'h0, div_done}, 32'h0);
    endtask

    // Main sequence
    initial begin
        int cyc;
        reset = 1'b1; mult_en = 1'b0; alu_hi = '0; alu_lo = '0; div_start = 1'b0;
        unsign = 1'b0; dividend = '0; divisor = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        #12;
        checkOutput("rst_hi", hi, 32'h0);
        checkOutput("rst_lo", lo, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, div_done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Multiply capture and moves
        applyStimulus("mult", 1'b1, 1'b0, 1'b0, 32'h9, 32'hFFFF_CB26, 32'h0,
                      32'h9, 32'hFFFF_CB26);
        applyStimulus("mthiMtlo", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h1234_5678,
                      32'h1234_5678, 32'h1234_5678);
        applyStimulus("mthiOnly", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hAAAA_0000,
                      32'hAAAA_0000, 32'h1234_5678);
        applyStimulus("mtloOnly", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0BAD_F00D,
                      32'hAAAA_0000, 32'h0BAD_F00D);

        // Unsigned and signed divides
        applyDivide("divu_big", 1'b1, 32'hFFFF_FAB7, 32'd10, 32'd3, 32'd429496594, 1'b0, 1'b0);
        applyDivide("div_neg", 1'b0, 32'hFFFF_FAB7, 32'd10, 32'hFFFF_FFFD, 32'hFFFF_FF79, 1'b0, 1'b0);
        applyDivide("div_34_10", 1'b0, 32'd34, 32'd10, 32'd4, 32'd3, 1'b0, 1'b0);
        applyDivide("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        applyDivide("div_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        applyDivide("divu_max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0);

        // Divide by zero
        applyDivide("div_zero", 1'b0, 32'd34, 32'd0, 32'd34, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyDivide("divu_zero", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Divide wins over a simultaneous multiply; lockout during RUN
        applyDivide("div_vs_mult", 1'b1, 32'd34, 32'd10, 32'd4, 32'd3, 1'b1, 1'b0);
        applyDivide("div_lockout", 1'b1, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        unsign = 1'b1; dividend = 32'h1234_5678; divisor = 32'd3; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRst_hi", hi, 32'h0);
        checkOutput("midRst_lo", lo, 32'h0);
        checkOutput("midRst_busy", {31'h0, busy}, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("midRst_noDone", {31'h0, div_done}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        modelHi = 32'h0;
        modelLo = 32'h0;
        cyc = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_done) cyc++;
        end
        checkOutput("midRst_staysIdle", 32'(cyc), 32'd0);
        applyDivide("div_after_rst", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
